// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential unsigned restoring divider. Divides a 2N-bit
//                dividend by an N-bit divisor, producing an N-bit quotient
//                and N-bit remainder, one quotient bit per clock. Divide by
//                zero and quotient overflow are reported on the accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);

    localparam int             c_CNT_W = $clog2(N) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;

    logic [N:0]         r_rem;
    logic [N-1:0]       r_q;
    logic [N-1:0]       r_dvs;
    logic [c_CNT_W-1:0] r_cnt;

    logic [N-1:0]       r_quotient;
    logic [N-1:0]       r_remainder;
    logic               r_done;
    logic               r_div_zero;
    logic               r_overflow;

    logic               w_accept;
    logic               w_zero;
    logic               w_ovf;
    logic               w_last;
    logic [N:0]         w_shift;
    logic               w_ge;
    logic [N:0]         w_rem_new;
    logic [N-1:0]       w_q_new;

    // Operand classification and one restoring step of the partial remainder.
    // The partial remainder is always below the divisor, so its top bit is
    // zero before the shift and the shifted value fits in N+1 bits.
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_zero    = (divisor == '0);
    assign w_ovf     = (dividend[2*N-1:N] >= divisor);
    assign w_last    = (r_state == S_RUN) && (r_cnt == c_LAST);
    assign w_shift   = {r_rem[N-1:0], r_q[N-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_rem_new = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
    assign w_q_new   = {r_q[N-2:0], w_ge};

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state: error cases complete on the accept edge and stay idle.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start && !w_zero && !w_ovf) w_state_nx = S_RUN;
            S_RUN:   if (r_cnt == c_LAST)            w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Datapath, results and flags; results change only on done edges or rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_div_zero <= 1'b0;
                r_overflow <= 1'b0;
                r_dvs      <= divisor;
                if (w_zero) begin
                    r_div_zero  <= 1'b1;
                    r_quotient  <= '1;
                    r_remainder <= dividend[N-1:0];
                    r_done      <= 1'b1;
                end else if (w_ovf) begin
                    r_overflow  <= 1'b1;
                    r_quotient  <= '1;
                    r_remainder <= dividend[N-1:0];
                    r_done      <= 1'b1;
                end else begin
                    r_rem <= {1'b0, dividend[2*N-1:N]};
                    r_q   <= dividend[N-1:0];
                    r_cnt <= '0;
                end
            end else if (r_state == S_RUN) begin
                r_rem <= w_rem_new;
                r_q   <= w_q_new;
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (w_last) begin
                    r_quotient  <= w_q_new;
                    r_remainder <= w_rem_new[N-1:0];
                    r_done      <= 1'b1;
                end
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed and random self-checking bench for seq_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_zero;
    logic           overflow;

    int checks;
    int failures;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one start pulse and wait for done; returns edges from accept
    // to done (0 for same-edge done) and the number of samples with busy=1.
    task automatic do_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                         output int lat, output int bcnt);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        checks++;
        if ({busy, done, div_zero, overflow, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_state: got b=%b d=%b z=%b o=%b q=%h r=%h, expected all 0",
                     busy, done, div_zero, overflow, quotient, remainder);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [2*N-1:0] va [4] = '{16'd51, 16'd100, 16'd49, 16'hFEFF};
        logic [N-1:0]   vb [4] = '{8'd3, 8'd7, 8'd7, 8'hFF};
        logic [N-1:0]   vq [4] = '{8'd17, 8'd14, 8'd7, 8'hFF};
        logic [N-1:0]   vr [4] = '{8'd0, 8'd2, 8'd0, 8'hFE};
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], lat, bcnt);
            checks++;
            if (lat !== N || bcnt !== N) begin
                failures++;
                $display("FAIL basic_latency[%0d]: got lat=%0d busy=%0d expected %0d", i, lat, bcnt, N);
            end
            checks++;
            if (quotient !== vq[i] || remainder !== vr[i]) begin
                failures++;
                $display("FAIL basic_result[%0d]: got q=%h r=%h expected q=%h r=%h",
                         i, quotient, remainder, vq[i], vr[i]);
            end
            checks++;
            if (div_zero !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL basic_flags[%0d]: got z=%b o=%b b=%b expected 0 0 0",
                         i, div_zero, overflow, busy);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse[%0d]: got done=%b expected 0", i, done);
            end
        end
    endtask

    task automatic test_errors();
        int lat, bcnt;
        do_op(16'd1234, 8'd0, lat, bcnt);
        checks++;
        if (lat !== 0 || bcnt !== 0 || div_zero !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL div_zero_flags: got lat=%0d busy=%0d z=%b o=%b expected 0 0 1 0",
                     lat, bcnt, div_zero, overflow);
        end
        checks++;
        if (quotient !== 8'hFF || remainder !== 8'hD2) begin
            failures++;
            $display("FAIL div_zero_result: got q=%h r=%h expected q=ff r=d2", quotient, remainder);
        end
        tick(); tick();
        checks++;
        if (div_zero !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL div_zero_sticky: got z=%b done=%b expected 1 0", div_zero, done);
        end
        do_op(16'h0300, 8'd3, lat, bcnt);
        checks++;
        if (lat !== 0 || bcnt !== 0 || overflow !== 1'b1 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL overflow_flags: got lat=%0d busy=%0d o=%b z=%b expected 0 0 1 0",
                     lat, bcnt, overflow, div_zero);
        end
        checks++;
        if (quotient !== 8'hFF || remainder !== 8'h00) begin
            failures++;
            $display("FAIL overflow_result: got q=%h r=%h expected q=ff r=00", quotient, remainder);
        end
        // A legal start clears the sticky flag on its accept edge
        dividend = 16'd100; divisor = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1 || quotient !== 8'hFF) begin
            failures++;
            $display("FAIL flag_clear: got o=%b b=%b q=%h expected 0 1 ff", overflow, busy, quotient);
        end
        for (int i = 0; i < 40 && !done; i++) tick();
        tick();
    endtask

    task automatic test_ignore_start();
        int lat;
        dividend = 16'd200; divisor = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        tick(); tick(); lat = 2;
        dividend = 16'd1000; divisor = 8'd3; start = 1'b1;
        tick(); lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== N || quotient !== 8'd22 || remainder !== 8'd2) begin
            failures++;
            $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d expected %0d 22 2",
                     lat, quotient, remainder, N);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || quotient !== 8'd22) begin
            failures++;
            $display("FAIL ignore_no_restart: got b=%b q=%0d expected 0 22", busy, quotient);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        dividend = 16'd100; divisor = 8'd7; start = 1'b1;
        tick();
        dividend = 16'd49;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== N || quotient !== 8'd14 || remainder !== 8'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d b=%b expected %0d 14 2 0",
                     lat, quotient, remainder, busy, N);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got b=%b done=%b expected 1 0", busy, done);
        end
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== N || quotient !== 8'd7 || remainder !== 8'd0) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected %0d 7 0",
                     lat, quotient, remainder, N);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        dividend = 16'd51; divisor = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got b=%b done=%b q=%h r=%h expected 0 0 00 00",
                     busy, done, quotient, remainder);
        end
        // rst and start on the same edge: nothing accepted
        start = 1'b1; dividend = 16'd100; divisor = 8'd7;
        tick();
        start = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_start: got b=%b done=%b expected 0 0", busy, done);
        end
        do_op(16'd100, 8'd7, lat, bcnt);
        checks++;
        if (lat !== N || quotient !== 8'd14 || remainder !== 8'd2) begin
            failures++;
            $display("FAIL after_reset: got lat=%0d q=%0d r=%0d expected %0d 14 2",
                     lat, quotient, remainder, N);
        end
        tick();
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [N-1:0]   b;
        logic [2*N-1:0] a;
        logic [N-1:0]   eq, er;
        for (int i = 0; i < 2000; i++) begin
            b  = N'($urandom_range(1, 255));
            a  = {N'($urandom_range(0, int'(b) - 1)), N'($urandom_range(0, 255))};
            eq = N'(a / {8'd0, b});
            er = N'(a % {8'd0, b});
            do_op(a, b, lat, bcnt);
            checks++;
            if (quotient !== eq || remainder !== er || lat !== N || overflow !== 1'b0) begin
                failures++;
                $display("FAIL random[%0d]: %h/%h got q=%h r=%h lat=%0d expected q=%h r=%h lat=%0d",
                         i, a, b, quotient, remainder, lat, eq, er, N);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_errors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
